shift_add_mult16: RTL and testbench



---
 rtl/shift_add_mult16.sv | 167 ++++++++++++++++
 tb/tb_shift_add_mult16.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult16.sv
// -----------------------------------------------------------------------------
// shift_add_mult16
//
// Purpose:
//    Sequential 16x16 unsigned shift-and-add multiplier. A single 16-bit
//    carry-ripple adder is reused for 16 iterations to build a 32-bit product.
//    Operands arrive over a valid/ready handshake; the product leaves over a
//    second valid/ready handshake and is held until the consumer takes it.
//
// Ports:
//    clk            in   1   rising-edge clock
//    rst_n          in   1   synchronous, active-low reset
//    i_start_valid  in   1   operand pair i_a/i_b is valid
//    o_start_ready  out  1   block can accept operands (IDLE and rst_n=1)
//    i_a            in  16   multiplicand, sampled on accept
//    i_b            in  16   multiplier, sampled on accept
//    o_res_valid    out  1   product is valid (DONE state)
//    i_res_ready    in   1   consumer takes the product
//    o_product      out 32   i_a * i_b, unsigned
//
// Configuration macro:
//    MUL_ZERO_BYPASS_EN  - when defined, a zero operand on accept skips the
//                          iterations and goes straight to DONE with product 0.
// -----------------------------------------------------------------------------
module shift_add_mult16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start_valid,
   output logic        o_start_ready,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic        o_res_valid,
   input  logic        i_res_ready,
   output logic [31:0] o_product
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_mcand;
   // Bit 32 of the conceptual 33-bit accumulator is always 0 after a shift,
   // so only the lower 32 bits are stored: {sum[16:0], lo[15:1]}.
   logic [31:0] r_p;
   logic [4:0]  r_cnt;

   logic        w_accept;
   logic        w_zero_op;
   logic        w_last_iter;
   logic [15:0] w_add_b;
   logic [16:0] w_sum;

   // 16-bit carry-ripple adder with carry-in tied to 0; returns {carry, sum}.
   function automatic logic [16:0] ripple_add16(input logic [15:0] op_a,
                                                input logic [15:0] op_b);
      logic [15:0] sum_bits;
      logic        carry;
      carry    = 1'b0;
      sum_bits = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         sum_bits[i] = op_a[i] ^ op_b[i] ^ carry;
         carry       = (op_a[i] & op_b[i]) | (carry & (op_a[i] ^ op_b[i]));
      end
      return {carry, sum_bits};
   endfunction

   // Adder operand mux and add: high half plus multiplicand when the LSB is set.
   always_comb begin
      w_add_b = r_p[0] ? r_mcand : 16'h0000;
      w_sum   = ripple_add16(r_p[31:16], w_add_b);
   end

   // Handshake and iteration-control decodes.
   always_comb begin
      w_accept    = i_start_valid && o_start_ready;
      w_last_iter = (r_cnt == 5'd15);
`ifdef MUL_ZERO_BYPASS_EN
      w_zero_op   = (i_a == 16'h0000) || (i_b == 16'h0000);
`else
      w_zero_op   = 1'b0;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_zero_op ? ST_DONE : ST_BUSY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (w_last_iter) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (i_res_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM outputs; start_ready is additionally gated by rst_n so no operand is
   // taken during a reset cycle.
   always_comb begin
      o_start_ready = rst_n && (r_state == ST_IDLE);
      o_res_valid   = (r_state == ST_DONE);
   end

   // Datapath: operand load, shift-and-add iterations, hold in DONE/IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcand <= 16'h0000;
         r_p     <= 32'h0000_0000;
         r_cnt   <= 5'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_mcand <= i_a;
                  r_p     <= w_zero_op ? 32'h0000_0000 : {16'h0000, i_b};
                  r_cnt   <= 5'd0;
               end
            end
            ST_BUSY: begin
               r_p   <= {w_sum, r_p[15:1]};
               r_cnt <= r_cnt + 5'd1;
            end
            ST_DONE: begin
               r_p <= r_p;
            end
            default: begin
               r_cnt <= 5'd0;
            end
         endcase
      end
   end

   assign o_product = r_p;

endmodule

// File: tb/tb_shift_add_mult16.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult16
//
// Purpose:
//    Directed self-checking bench for shift_add_mult16. Expected products and
//    latencies are hand-computed constants. Honors MUL_ZERO_BYPASS_EN for the
//    zero-operand latency.
// -----------------------------------------------------------------------------
module tb_shift_add_mult16;

   logic        clk;
   logic        rst_n;
   logic        i_start_valid;
   logic        o_start_ready;
   logic [15:0] i_a;
   logic [15:0] i_b;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [31:0] o_product;

   int checks;
   int failures;
   int unsigned cyc;
   int unsigned acc_cyc;
   int unsigned prev_acc;

   shift_add_mult16 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start_valid (i_start_valid),
      .o_start_ready (o_start_ready),
      .i_a           (i_a),
      .i_b           (i_b),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_product     (o_product)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure accept spacing.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Safety net against a hung run.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present an operand pair and return just after its accept edge.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      int w;
      w = 0;
      while (!o_start_ready && w < 40) begin
         tick();
         w++;
      end
      check_eq("start_ready_before_accept", {31'd0, o_start_ready}, 32'd1);
      i_a           = a;
      i_b           = b;
      i_start_valid = 1'b1;
      tick();
      acc_cyc       = cyc;
      i_start_valid = 1'b0;
   endtask

   // Wait for res_valid, checking latency (edges after accept) and product.
   task automatic wait_result(input string tag, input int exp_lat,
                              input logic [31:0] exp_prod);
      int lat;
      lat = 0;
      while (!o_res_valid && lat < 40) begin
         tick();
         lat++;
      end
      check_eq({tag, "_latency"}, lat, exp_lat);
      check_eq({tag, "_product"}, o_product, exp_prod);
   endtask

   // Pop with res_ready=1 and check return to IDLE.
   task automatic pop_check(input string tag);
      i_res_ready = 1'b1;
      tick();
      check_eq({tag, "_pop_valid"}, {31'd0, o_res_valid}, 32'd0);
      check_eq({tag, "_pop_ready"}, {31'd0, o_start_ready}, 32'd1);
   endtask

   initial begin
      int exp_zero_lat;
      logic [15:0] ta [3];
      logic [15:0] tb [3];
      logic [31:0] tp [3];

      checks        = 0;
      failures      = 0;
      cyc           = 0;
      acc_cyc       = 0;
      prev_acc      = 0;
      rst_n         = 1'b0;
      i_start_valid = 1'b0;
      i_a           = 16'h0000;
      i_b           = 16'h0000;
      i_res_ready   = 1'b0;

      // Reset state.
      tick();
      tick();
      check_eq("rst_start_ready", {31'd0, o_start_ready}, 32'd0);
      check_eq("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
      check_eq("rst_product", o_product, 32'h0000_0000);
      rst_n = 1'b1;
      #1;
      check_eq("rst_release_ready", {31'd0, o_start_ready}, 32'd1);

      // 3*5 with res_ready held high.
      i_res_ready = 1'b1;
      start_op(16'd3, 16'd5);
      check_eq("m3x5_busy_ready", {31'd0, o_start_ready}, 32'd0);
      wait_result("m3x5", 16, 32'h0000_000F);
      pop_check("m3x5");

      // Full carry path.
      start_op(16'hFFFF, 16'hFFFF);
      wait_result("mffff", 16, 32'hFFFE_0001);
      pop_check("mffff");

      // Back-pressure: result held, pending operands not accepted early.
      i_res_ready = 1'b0;
      start_op(16'h1234, 16'hABCD);
      wait_result("m1234", 16, 32'h0C37_4FA4);
      i_a           = 16'd2;
      i_b           = 16'd3;
      i_start_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check_eq("hold_valid", {31'd0, o_res_valid}, 32'd1);
         check_eq("hold_product", o_product, 32'h0C37_4FA4);
         check_eq("hold_no_ready", {31'd0, o_start_ready}, 32'd0);
      end
      i_res_ready = 1'b1;
      tick();
      check_eq("hold_pop_valid", {31'd0, o_res_valid}, 32'd0);
      check_eq("hold_pop_ready", {31'd0, o_start_ready}, 32'd1);
      check_eq("hold_pop_product_kept", o_product, 32'h0C37_4FA4);
      tick();
      i_start_valid = 1'b0;
      check_eq("pend_accepted_busy", {31'd0, o_start_ready}, 32'd0);
      wait_result("m2x3", 16, 32'h0000_0006);
      pop_check("m2x3");

      // Reset during iteration 8.
      start_op(16'h1234, 16'h5678);
      repeat (7) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("midrst_valid", {31'd0, o_res_valid}, 32'd0);
      check_eq("midrst_product", o_product, 32'h0000_0000);
      check_eq("midrst_ready", {31'd0, o_start_ready}, 32'd1);
      start_op(16'd7, 16'd9);
      wait_result("m7x9", 16, 32'h0000_003F);
      pop_check("m7x9");

      // Zero operand.
`ifdef MUL_ZERO_BYPASS_EN
      exp_zero_lat = 0;
`else
      exp_zero_lat = 16;
`endif
      start_op(16'h0000, 16'h00FF);
      wait_result("mzero", exp_zero_lat, 32'h0000_0000);
      pop_check("mzero");

      // Back-to-back pairs at minimum initiation interval.
      ta[0] = 16'h0001; tb[0] = 16'h0001; tp[0] = 32'h0000_0001;
      ta[1] = 16'h8000; tb[1] = 16'h0002; tp[1] = 32'h0001_0000;
      ta[2] = 16'hFFFF; tb[2] = 16'h0001; tp[2] = 32'h0000_FFFF;
      for (int n = 0; n < 3; n++) begin
         start_op(ta[n], tb[n]);
         if (n > 0) begin
            check_eq("b2b_spacing", acc_cyc - prev_acc, 32'd18);
         end
         prev_acc = acc_cyc;
         wait_result("b2b", 16, tp[n]);
         pop_check("b2b");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
